irq_sequencer: RTL and testbench
================================

# irq_sequencer

Priority interrupt sequencer for the interrupts datapath. It latches edge-triggered requests from N sources, applies a software-loaded mask and selects the highest-priority unmasked source. It handshakes the selection with the CPU control unit, then pulses the load strobe of the return-address register (a `register_sload` instance, `l` input) exactly once per accepted interrupt. It holds an in-service state until end-of-interrupt; there is no nesting.

## Interface
- `N`, 8: number of interrupt sources; must be 2..16.
- `VW`, `$clog2(N)`: width of the vector output.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  N  request lines; a 0→1 transition on bit k is one event for source k.
- `mask_i`  in  N  new mask value; bit = 1 disables that source.
- `mask_l`  in  1  synchronous load of `mask_i` into the mask register.
- `ack`  in  1  CPU accepts the presented interrupt; honoured only while `irq` = 1.
- `eoi`  in  1  end of interrupt; honoured only in SERVICE.
- `irq`  out  N/A 1  interrupt request to CPU (registered).
- `vec`  out  VW  index of the presented or in-service source (registered).
- `epc_l`  out  1  one-cycle load strobe for the return-address register.
- `in_service`  out  1  high in SERVICE.
- `pending_o`  out  N  current pending register, for status readback.

## Operation
- Edge detect: `rise = req & ~req_q`; `req_q <= req` every cycle.
- Pending update: `pending <= (pending & ~clr) | rise`. `clr` is the one-hot of `vec` on an honoured `ack`; otherwise 0. If a new rise and the clear hit the same bit in the same cycle, the set wins.
- Mask: `mask <= mask_i` when `mask_l`. Masking never clears pending; the bit fires once unmasked.
- Priority: the lowest index among `pending & ~mask` wins.
- FSM states:
  - IDLE: if any unmasked pending bit, go to REQ. `vec` ← winner, `irq` ← 1.
  - REQ: `vec` is frozen. `irq` stays 1 until `ack`, even if the source becomes masked or a higher-priority request arrives. On `ack`: clear `pending[vec]`, `irq` ← 0, `epc_l` ← 1, go to SAVE.
  - SAVE: `epc_l` = 1 for this cycle only. Unconditionally go to SERVICE; `epc_l` ← 0, `in_service` ← 1.
  - SERVICE: `vec` is held. On `eoi`: `in_service` ← 0, go to IDLE.
- `ack` outside REQ and `eoi` outside SERVICE are ignored and have no side effects.
- `ack` and `eoi` asserted together are resolved per state; they are never both honoured.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - state IDLE; `pending` 0; `mask` all ones (all disabled); `req_q` all ones, so a level held through reset creates no event.
  - `irq` 0, `vec` 0, `epc_l` 0, `in_service` 0.
- Reset wins over every other input and aborts REQ, SAVE or SERVICE immediately. Pending events are lost.
- `req[k]` rises in cycle 0 (source unmasked, FSM in IDLE):
  - `pending[k]` = 1 in cycle 1;
  - `irq` = 1 and `vec` = k in cycle 2.
- `ack` sampled in cycle n:
  - `irq` = 0 and `epc_l` = 1 in cycle n+1;
  - `in_service` = 1 in cycle n+2.
- `eoi` sampled in cycle m: `in_service` = 0 in m+1, state IDLE. The earliest next `irq` is in m+2.
- `mask_l` in cycle t affects arbitration from cycle t+1.
- An event on a source that is already pending (re-raised before service) is merged; it is not counted twice.

## Structure
- Shared include `irq_defs.vh` holds:
  - state encodings `S_IDLE`, `S_REQ`, `S_SAVE`, `S_SERVICE` (2-bit);
  - the default `N`.
- Sub-module `prio_enc_lsb` (parameter `N`): combinational lowest-index encoder with outputs `idx[VW-1:0]` and `valid`.
- The mask is a plain register with synchronous load inside this block; no `register_sload` instance is used for it.

## Test plan
- Reset, mask ← 8'h00; pulse `req[5]` in cycle 0 → `irq` = 1, `vec` = 5 in cycle 2; `ack` in cycle 4 → `epc_l` = 1 only in cycle 5, `in_service` = 1 from cycle 6; `eoi` → `in_service` = 0 next cycle.
- `req[6]` and `req[2]` rise in the same cycle → `vec` = 2 first. After `eoi`, `vec` = 6 with `irq` = 1 two cycles later.
- While in REQ with `vec` = 4, `req[1]` rises → `vec` stays 4 until `ack`. `irq` for source 1 follows after `eoi`.
- Mask = 8'h08, `req[3]` pulses → no `irq` and `pending_o` = 8'h08. Load mask 8'h00 → `irq` with `vec` = 3 two cycles after `mask_l`.
- Edge cases:
  - `ack` in IDLE and `eoi` in REQ → no state change;
  - `req[0]` rises in the same cycle as the `ack` for `vec` = 0 → `pending_o[0]` stays 1;
  - `req` held high through reset → no event.
- `rst_n` = 0 during SAVE → next cycle all outputs 0, mask = all ones, `pending_o` = 0.

Source files
------------

// File: rtl/irq_sequencer_pkg.sv
// Shared types and defaults for the interrupt sequencer.
package irq_sequencer_pkg;

  // Default number of interrupt sources.
  localparam int unsigned NDefault = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StSave    = 2'd2,
    StService = 2'd3
  } irq_state_e;

endpackage

// File: rtl/irq_sequencer_prio_enc_lsb.sv
// Combinational priority encoder: lowest set index wins.
module irq_sequencer_prio_enc_lsb #(
  parameter int unsigned N  = 8,
  parameter int unsigned VW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [VW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = VW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Priority interrupt sequencer: edge-latched requests, mask, lowest-index
// arbitration and a REQ/SAVE/SERVICE handshake with the CPU control unit.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int unsigned N  = NDefault,
  parameter int unsigned VW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask_i,
  input  logic          mask_l,
  input  logic          ack,
  input  logic          eoi,
  output logic          irq,
  output logic [VW-1:0] vec,
  output logic          epc_l,
  output logic          in_service,
  output logic [N-1:0]  pending_o
);

  irq_state_e    state_q;
  logic [N-1:0]  req_q;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  mask_q;
  logic          irq_q, epc_l_q, in_service_q;
  logic [VW-1:0] vec_q;

  logic [N-1:0]  rise;
  logic [N-1:0]  clr;
  logic          ack_hon;
  logic [VW-1:0] win_idx;
  logic          win_valid;

  // Edge detect and pending update; a same-cycle rise beats the clear.
  always_comb begin
    rise      = req & ~req_q;
    ack_hon   = (state_q == StReq) && ack;
    clr       = ack_hon ? (N'(1) << vec_q) : '0;
    pending_d = (pending_q & ~clr) | rise;
  end

  irq_sequencer_prio_enc_lsb #(
    .N  (N),
    .VW (VW)
  ) u_prio_enc (
    .req_i   (pending_q & ~mask_q),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // Request history, pending and mask registers. req_q resets to ones so a
  // level held through reset does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q     <= '1;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      if (mask_l) begin
        mask_q <= mask_i;
      end
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      irq_q        <= 1'b0;
      vec_q        <= '0;
      epc_l_q      <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            state_q <= StReq;
            vec_q   <= win_idx;
            irq_q   <= 1'b1;
          end
        end
        // vec is frozen here regardless of mask changes or new arrivals.
        StReq: begin
          if (ack) begin
            state_q <= StSave;
            irq_q   <= 1'b0;
            epc_l_q <= 1'b1;
          end
        end
        StSave: begin
          state_q      <= StService;
          epc_l_q      <= 1'b0;
          in_service_q <= 1'b1;
        end
        StService: begin
          if (eoi) begin
            state_q      <= StIdle;
            in_service_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign irq        = irq_q;
  assign vec        = vec_q;
  assign epc_l      = epc_l_q;
  assign in_service = in_service_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: stimulus pushes expected vectors,
// a monitor pops and compares on every rising irq.
module tb_irq_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] mask_i;
  logic       mask_l;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vec;
  logic       epc_l;
  logic       in_service;
  logic [7:0] pending_o;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int exp_epc  = 0;
  int epc_seen = 0;

  irq_sequencer #(
    .N  (8),
    .VW (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask_i     (mask_i),
    .mask_l     (mask_l),
    .ack        (ack),
    .eoi        (eoi),
    .irq        (irq),
    .vec        (vec),
    .epc_l      (epc_l),
    .in_service (in_service),
    .pending_o  (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ack in REQ, then eoi once in SERVICE; returns in the cycle after eoi.
  task automatic service();
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_epc++;
    step();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  // Monitor: every rising irq must match the next expected vector.
  initial begin
    logic irq_prev;
    int   e;
    irq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (epc_l === 1'b1) epc_seen++;
      if (irq === 1'b1 && irq_prev !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_irq actual vec=%0d required=no irq", vec);
        end else begin
          e = exp_q.pop_front();
          if (vec !== 3'(e)) begin
            failures++;
            $display("FAIL irq_vec actual=%0d required=%0d", vec, e);
          end
        end
      end
      irq_prev = irq;
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; mask_i = '0; mask_l = 1'b0; ack = 1'b0; eoi = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("reset_irq", irq, 0);
    check("reset_vec", vec, 0);
    check("reset_epc", epc_l, 0);
    check("reset_insvc", in_service, 0);
    check("reset_pending", pending_o, 8'h00);

    // Basic flow on source 5.
    mask_i = 8'h00; mask_l = 1'b1;
    step();
    mask_l = 1'b0;
    exp_q.push_back(5);
    req = 8'h20;          // cycle 0
    step();
    req = 8'h00;          // cycle 1
    check("s1_pending_c1", pending_o, 8'h20);
    check("s1_irq_c1", irq, 0);
    step();               // cycle 2
    check("s1_irq_c2", irq, 1);
    check("s1_vec_c2", vec, 5);
    step();               // cycle 3
    step();               // cycle 4
    ack = 1'b1;
    step();               // cycle 5
    ack = 1'b0;
    exp_epc++;
    check("s1_irq_c5", irq, 0);
    check("s1_epc_c5", epc_l, 1);
    check("s1_insvc_c5", in_service, 0);
    check("s1_pending_c5", pending_o, 8'h00);
    step();               // cycle 6
    check("s1_epc_c6", epc_l, 0);
    check("s1_insvc_c6", in_service, 1);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    check("s1_insvc_eoi", in_service, 0);

    // Simultaneous sources 6 and 2: 2 first, then 6.
    exp_q.push_back(2);
    exp_q.push_back(6);
    req = 8'h44;
    step();
    req = 8'h00;
    step();
    check("s2_vec_first", vec, 2);
    service();
    check("s2_irq_m1", irq, 0);
    step();
    check("s2_irq_m2", irq, 1);
    check("s2_vec_m2", vec, 6);
    service();
    step();

    // Higher priority arrival while in REQ does not steal vec.
    exp_q.push_back(4);
    exp_q.push_back(1);
    req = 8'h10;
    step();
    req = 8'h00;
    step();
    req = 8'h02;
    step();
    req = 8'h00;
    step();
    check("s3_vec_frozen", vec, 4);
    check("s3_pending", pending_o, 8'h12);
    service();
    step();
    check("s3_vec_next", vec, 1);
    service();
    step();

    // Masked source stays pending, fires once unmasked.
    mask_i = 8'h08; mask_l = 1'b1;
    step();
    mask_l = 1'b0;
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    step();
    check("s4_masked_irq", irq, 0);
    check("s4_masked_pending", pending_o, 8'h08);
    exp_q.push_back(3);
    mask_i = 8'h00; mask_l = 1'b1;
    step();
    mask_l = 1'b0;
    check("s4_irq_t1", irq, 0);
    step();
    check("s4_irq_t2", irq, 1);
    check("s4_vec_t2", vec, 3);
    service();
    step();

    // ack in IDLE ignored.
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("e_ack_idle_epc", epc_l, 0);
    check("e_ack_idle_irq", irq, 0);
    check("e_ack_idle_insvc", in_service, 0);

    // eoi in REQ ignored.
    exp_q.push_back(2);
    req = 8'h04;
    step();
    req = 8'h00;
    step();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    check("e_eoi_req_irq", irq, 1);
    check("e_eoi_req_insvc", in_service, 0);
    check("e_eoi_req_vec", vec, 2);
    service();
    step();

    // Rise on source 0 coincident with its ack: set wins.
    exp_q.push_back(0);
    exp_q.push_back(0);
    req = 8'h01;
    step();
    req = 8'h00;
    step();
    req = 8'h01; ack = 1'b1;
    step();
    req = 8'h00; ack = 1'b0;
    exp_epc++;
    check("e_setwins_pending", pending_o, 8'h01);
    check("e_setwins_epc", epc_l, 1);
    step();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    step();
    check("e_setwins_refire", irq, 1);
    service();
    step();

    // Level held through reset creates no event.
    req = 8'hFF;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("e_hold_pending", pending_o, 8'h00);
    mask_i = 8'h00; mask_l = 1'b1;
    step();
    mask_l = 1'b0;
    step();
    step();
    check("e_hold_irq", irq, 0);
    req = 8'h00;
    step();

    // Reset during SAVE.
    exp_q.push_back(1);
    req = 8'h0A;
    step();
    req = 8'h00;
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_epc++;
    check("r_save_epc", epc_l, 1);
    check("r_save_pending", pending_o, 8'h08);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("r_irq", irq, 0);
    check("r_vec", vec, 0);
    check("r_epc", epc_l, 0);
    check("r_insvc", in_service, 0);
    check("r_pending", pending_o, 8'h00);
    step();
    req = 8'h08;
    step();
    req = 8'h00;
    check("r_pending_new", pending_o, 8'h08);
    step();
    step();
    check("r_mask_all_ones", irq, 0);

    check("sb_queue_empty", exp_q.size(), 0);
    check("epc_pulse_count", epc_seen, exp_epc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
